// File: rtl/vga_pkg.sv
// Shared VGA timing constants and types for the 640x480 @ 60 Hz raster.
// The totals are derived from the porch lengths so that every figure comes from one source.
package vga_pkg;

   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FRONT  = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BACK   = 48;
   localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FRONT  = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BACK   = 33;
   localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

   localparam int VGA_COORD_W  = 10;
   localparam int VGA_FCOUNT_W = 8;

   // Phase of one raster axis. Both axes walk this order and wrap back to ACTIVE.
   typedef enum logic [1:0] {
      ACTIVE = 2'd0,
      FRONT  = 2'd1,
      SYNC   = 2'd2,
      BACK   = 2'd3
   } vga_phase_t;

   // Snapshot of both phase FSMs, exported for observation.
   typedef struct packed {
      vga_phase_t h_phase;
      vga_phase_t v_phase;
   } vga_dbg_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a position counter plus its ACTIVE/FRONT/SYNC/BACK phase FSM.
// The phase register always describes the current count. The next-state values are
// also exported, so a parent can register decodes that line up with the count.
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int ACTIVE_LEN = VGA_H_ACTIVE,
   parameter int FRONT_LEN  = VGA_H_FRONT,
   parameter int SYNC_LEN   = VGA_H_SYNC,
   parameter int BACK_LEN   = VGA_H_BACK,
   parameter int W          = VGA_COORD_W
) (
   input  logic         vga_clk,
   input  logic         reset_n,
   input  logic         adv,
   output logic [W-1:0] count,
   output vga_phase_t   phase,
   output vga_phase_t   phase_nxt,
   output logic         wrap
);

   localparam int TOTAL = ACTIVE_LEN + FRONT_LEN + SYNC_LEN + BACK_LEN;

   // Last count value belonging to each phase.
   localparam logic [W-1:0] LAST_ACTIVE = W'(ACTIVE_LEN - 1);
   localparam logic [W-1:0] LAST_FRONT  = W'(ACTIVE_LEN + FRONT_LEN - 1);
   localparam logic [W-1:0] LAST_SYNC   = W'(ACTIVE_LEN + FRONT_LEN + SYNC_LEN - 1);
   localparam logic [W-1:0] LAST_BACK   = W'(TOTAL - 1);

   logic [W-1:0] count_nxt;

   // State register: the count and its phase, both cleared to the start of ACTIVE.
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
         phase <= ACTIVE;
      end else begin
         count <= count_nxt;
         phase <= phase_nxt;
      end
   end

   // Next state: step the count and leave each phase on its last count value.
   always_comb begin
      count_nxt = count;
      phase_nxt = phase;
      if (adv) begin
         if (count == LAST_BACK) begin
            count_nxt = '0;
         end else begin
            count_nxt = count + W'(1);
         end
         case (phase)
            ACTIVE:  if (count == LAST_ACTIVE) phase_nxt = FRONT;
            FRONT:   if (count == LAST_FRONT)  phase_nxt = SYNC;
            SYNC:    if (count == LAST_SYNC)   phase_nxt = BACK;
            BACK:    if (count == LAST_BACK)   phase_nxt = ACTIVE;
            default: phase_nxt = ACTIVE;
         endcase
      end
   end

   // Outputs: wrap flags the advance that takes the count from its last value back to 0.
   always_comb begin
      wrap = adv && (count == LAST_BACK);
   end

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480 @ 60 Hz raster timing from the 25 MHz pixel clock.
// Each output flop loads from the axis counters' next-state values. Every output therefore
// changes on the same edge as DrawX/DrawY and describes the same pixel, with no added latency.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = VGA_H_ACTIVE,
   parameter int H_FRONT  = VGA_H_FRONT,
   parameter int H_SYNC   = VGA_H_SYNC,
   parameter int H_BACK   = VGA_H_BACK,
   parameter int V_ACTIVE = VGA_V_ACTIVE,
   parameter int V_FRONT  = VGA_V_FRONT,
   parameter int V_SYNC   = VGA_V_SYNC,
   parameter int V_BACK   = VGA_V_BACK
) (
   input  logic                    vga_clk,
   input  logic                    reset_n,
   output logic [VGA_COORD_W-1:0]  DrawX,
   output logic [VGA_COORD_W-1:0]  DrawY,
   output logic                    blank,
   output logic                    hs,
   output logic                    vs,
   output logic                    frame_start,
   output logic                    vblank_start,
   output logic [VGA_FCOUNT_W-1:0] frame_count,
   output vga_dbg_t                dbg_state
);

   vga_phase_t h_phase;
   vga_phase_t h_phase_nxt;
   vga_phase_t v_phase;
   vga_phase_t v_phase_nxt;
   logic       h_wrap;
   logic       v_wrap;

   // Horizontal axis advances every pixel clock.
   vga_axis_counter #(
      .ACTIVE_LEN (H_ACTIVE),
      .FRONT_LEN  (H_FRONT),
      .SYNC_LEN   (H_SYNC),
      .BACK_LEN   (H_BACK),
      .W          (VGA_COORD_W)
   ) u_h_axis (
      .vga_clk   (vga_clk),
      .reset_n   (reset_n),
      .adv       (1'b1),
      .count     (DrawX),
      .phase     (h_phase),
      .phase_nxt (h_phase_nxt),
      .wrap      (h_wrap)
   );

   // Vertical axis advances once per line, on the horizontal wrap.
   // Its wrap therefore already includes the horizontal wrap and marks the end of a frame.
   vga_axis_counter #(
      .ACTIVE_LEN (V_ACTIVE),
      .FRONT_LEN  (V_FRONT),
      .SYNC_LEN   (V_SYNC),
      .BACK_LEN   (V_BACK),
      .W          (VGA_COORD_W)
   ) u_v_axis (
      .vga_clk   (vga_clk),
      .reset_n   (reset_n),
      .adv       (h_wrap),
      .count     (DrawY),
      .phase     (v_phase),
      .phase_nxt (v_phase_nxt),
      .wrap      (v_wrap)
   );

   // Expose both phase FSMs for observation.
   always_comb begin
      dbg_state.h_phase = h_phase;
      dbg_state.v_phase = v_phase;
   end

   // Registered decodes and frame pulses, loaded from the pixel the counters are moving to.
   // vblank_start fires on the V transition ACTIVE->FRONT, which lands exactly on (0,V_ACTIVE).
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         blank        <= 1'b1;
         hs           <= 1'b1;
         vs           <= 1'b1;
         frame_start  <= 1'b0;
         vblank_start <= 1'b0;
         frame_count  <= '0;
      end else begin
         blank        <= (h_phase_nxt == ACTIVE) && (v_phase_nxt == ACTIVE);
         hs           <= (h_phase_nxt != SYNC);
         vs           <= (v_phase_nxt != SYNC);
         frame_start  <= v_wrap;
         vblank_start <= (v_phase == ACTIVE) && (v_phase_nxt == FRONT);
         if (v_wrap) begin
            frame_count <= frame_count + VGA_FCOUNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen. DUT a uses the default 640x480 timing. DUT b uses a shrunken
// 4/1/1/1 x 2/1/1/1 raster, so that whole frames and the frame_count wrap fit in a short run.
// Directed expectations go into a tagged queue, and a monitor compares them at the sample slot.
// A spec-level per-pixel model also checks every cycle.
`timescale 1ns/1ps
module tb_vga_timing_gen;
   import vga_pkg::*;

   localparam int SH_A = 4, SH_F = 1, SH_S = 1, SH_B = 1;
   localparam int SV_A = 2, SV_F = 1, SV_S = 1, SV_B = 1;
   localparam int SH_T = 7, SV_T = 5;
   localparam int DH_T = 800, DV_T = 525;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       blank;
      logic       hs;
      logic       vs;
      logic       fs;
      logic       vbs;
      logic [7:0] fc;
   } obs_t;

   // ---------------- clock / reset ----------------
   logic vga_clk = 1'b0;
   logic rst_a_n;
   logic rst_b_n;
   always #20 vga_clk = ~vga_clk;

   logic [9:0] a_x, a_y, b_x, b_y;
   logic       a_blank, a_hs, a_vs, a_fs, a_vbs;
   logic       b_blank, b_hs, b_vs, b_fs, b_vbs;
   logic [7:0] a_fc, b_fc;
   vga_dbg_t   a_dbg, b_dbg;

   vga_timing_gen u_dut_a (
      .vga_clk      (vga_clk),
      .reset_n      (rst_a_n),
      .DrawX        (a_x),
      .DrawY        (a_y),
      .blank        (a_blank),
      .hs           (a_hs),
      .vs           (a_vs),
      .frame_start  (a_fs),
      .vblank_start (a_vbs),
      .frame_count  (a_fc),
      .dbg_state    (a_dbg)
   );

   vga_timing_gen #(
      .H_ACTIVE (SH_A), .H_FRONT (SH_F), .H_SYNC (SH_S), .H_BACK (SH_B),
      .V_ACTIVE (SV_A), .V_FRONT (SV_F), .V_SYNC (SV_S), .V_BACK (SV_B)
   ) u_dut_b (
      .vga_clk      (vga_clk),
      .reset_n      (rst_b_n),
      .DrawX        (b_x),
      .DrawY        (b_y),
      .blank        (b_blank),
      .hs           (b_hs),
      .vs           (b_vs),
      .frame_start  (b_fs),
      .vblank_start (b_vbs),
      .frame_count  (b_fc),
      .dbg_state    (b_dbg)
   );

   // ---------------- scoreboard state ----------------
   int    n_checks = 0;
   int    n_pass   = 0;
   int    g        = 0;
   int    base     = 0;
   obs_t  exp_q[$];
   int    tag_q[$];
   bit    sel_q[$];
   string name_q[$];

   function automatic void check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endfunction

   function automatic obs_t obs_of(input bit sel);
      obs_t o;
      if (sel) o = {b_x, b_y, b_blank, b_hs, b_vs, b_fs, b_vbs, b_fc};
      else     o = {a_x, a_y, a_blank, a_hs, a_vs, a_fs, a_vbs, a_fc};
      return o;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic step(input int n);
      repeat (n) @(negedge vga_clk);
      #5;
   endtask

   // Expected DUT view m samples after the current base slot.
   task automatic expect_at(input bit sel, input int m, input string name,
                            input int x, input int y, input bit bl, input bit h,
                            input bit v, input bit f, input bit vb, input int fc);
      obs_t e;
      e = {10'(x), 10'(y), bl, h, v, f, vb, 8'(fc)};
      exp_q.push_back(e);
      tag_q.push_back(base + m);
      sel_q.push_back(sel);
      name_q.push_back(name);
   endtask

   // ---------------- monitor: pop and compare at the tagged sample slot ----------------
   always @(negedge vga_clk) begin
      obs_t act;
      g = g + 1;
      while (tag_q.size() > 0 && tag_q[0] <= g) begin
         n_checks++;
         act = obs_of(sel_q[0]);
         if (tag_q[0] < g) begin
            $display("FAIL %s: sample slot %0d passed before comparison (now %0d)",
                     name_q[0], tag_q[0], g);
         end else if (act == exp_q[0]) begin
            n_pass++;
         end else begin
            $display("FAIL %s: got x=%0d y=%0d blank=%0b hs=%0b vs=%0b fs=%0b vbs=%0b fc=%0d, expected x=%0d y=%0d blank=%0b hs=%0b vs=%0b fs=%0b vbs=%0b fc=%0d",
                     name_q[0], act.x, act.y, act.blank, act.hs, act.vs, act.fs, act.vbs, act.fc,
                     exp_q[0].x, exp_q[0].y, exp_q[0].blank, exp_q[0].hs, exp_q[0].vs,
                     exp_q[0].fs, exp_q[0].vbs, exp_q[0].fc);
         end
         void'(exp_q.pop_front());
         void'(tag_q.pop_front());
         void'(sel_q.pop_front());
         void'(name_q.pop_front());
      end
   end

   // ---------------- per-pixel reference model ----------------
   function automatic vga_phase_t phase_of(input int p, input int a, input int f, input int s);
      if (p < a)              return ACTIVE;
      else if (p < a + f)     return FRONT;
      else if (p < a + f + s) return SYNC;
      else                    return BACK;
   endfunction

   function automatic bit cyc_bad(input obs_t act, input vga_dbg_t dbg, input int x, input int y,
                                  input bit fs, input int fc, input int ha, input int hf,
                                  input int hsw, input int va, input int vf, input int vsw);
      obs_t     e;
      vga_dbg_t ed;
      e.x     = 10'(x);
      e.y     = 10'(y);
      e.blank = (x < ha) && (y < va);
      e.hs    = !((x >= ha + hf) && (x < ha + hf + hsw));
      e.vs    = !((y >= va + vf) && (y < va + vf + vsw));
      e.fs    = fs;
      e.vbs   = (x == 0) && (y == va);
      e.fc    = 8'(fc);
      ed.h_phase = phase_of(x, ha, hf, hsw);
      ed.v_phase = phase_of(y, va, vf, vsw);
      return (act != e) || (dbg != ed);
   endfunction

   int ma_x = 0, ma_y = 0, ma_fc = 0;
   int mb_x = 0, mb_y = 0, mb_fc = 0;
   bit ma_fs = 1'b0, mb_fs = 1'b0;

   // Model A: position advances each clock, line and frame wrap at the default totals.
   always @(posedge vga_clk) begin
      if (!rst_a_n) begin
         ma_x <= 0; ma_y <= 0; ma_fs <= 1'b0; ma_fc <= 0;
      end else begin
         ma_fs <= (ma_x == DH_T - 1) && (ma_y == DV_T - 1);
         if (ma_x == DH_T - 1) begin
            ma_x <= 0;
            if (ma_y == DV_T - 1) begin
               ma_y  <= 0;
               ma_fc <= (ma_fc + 1) % 256;
            end else begin
               ma_y <= ma_y + 1;
            end
         end else begin
            ma_x <= ma_x + 1;
         end
      end
   end

   // Model B: same behaviour on the shrunken raster.
   always @(posedge vga_clk) begin
      if (!rst_b_n) begin
         mb_x <= 0; mb_y <= 0; mb_fs <= 1'b0; mb_fc <= 0;
      end else begin
         mb_fs <= (mb_x == SH_T - 1) && (mb_y == SV_T - 1);
         if (mb_x == SH_T - 1) begin
            mb_x <= 0;
            if (mb_y == SV_T - 1) begin
               mb_y  <= 0;
               mb_fc <= (mb_fc + 1) % 256;
            end else begin
               mb_y <= mb_y + 1;
            end
         end else begin
            mb_x <= mb_x + 1;
         end
      end
   end

   int err_a = 0, err_b = 0;
   int hs_low_a = 0, hs_out_a = 0, fs_cnt_a = 0;
   int blank_b = 0, hs_low_b = 0, vs_low_b = 0, fs_cnt_b = 0, vbs_cnt_b = 0;
   int samp_b = 0, last_fs_b = -1, fs_per_b = 0;

   // Per-cycle comparison against the models, plus aggregate counters for directed checks.
   always @(negedge vga_clk) begin
      if (cyc_bad(obs_of(1'b0), a_dbg, ma_x, ma_y, ma_fs, ma_fc, 640, 16, 96, 480, 10, 2))
         err_a++;
      if (cyc_bad(obs_of(1'b1), b_dbg, mb_x, mb_y, mb_fs, mb_fc, SH_A, SH_F, SH_S, SV_A, SV_F, SV_S))
         err_b++;
      samp_b++;
      if (rst_a_n) begin
         if (!a_hs) hs_low_a++;
         if (!a_hs && !(a_x >= 10'd656 && a_x <= 10'd751)) hs_out_a++;
         if (a_fs) fs_cnt_a++;
      end
      if (rst_b_n) begin
         if (b_blank) blank_b++;
         if (!b_hs) hs_low_b++;
         if (!b_vs) vs_low_b++;
         if (b_vbs) vbs_cnt_b++;
         if (b_fs) begin
            fs_cnt_b++;
            if (last_fs_b >= 0) fs_per_b = samp_b - last_fs_b;
            last_fs_b = samp_b;
         end
      end
   end

   // ---------------- directed stimulus ----------------
   initial begin
      rst_a_n = 1'b0;
      rst_b_n = 1'b0;
      step(3);

      // Reset values while reset is held.
      base = g;
      expect_at(0, 1, "a_reset_values", 0, 0, 1, 1, 1, 0, 0, 0);
      expect_at(1, 1, "b_reset_values", 0, 0, 1, 1, 1, 0, 0, 0);
      step(1);

      // DUT a: first line of the default raster.
      rst_a_n = 1'b1;
      base = g;
      hs_low_a = 0; hs_out_a = 0;
      expect_at(0, 1,   "a_first_edge",   1,   0, 1, 1, 1, 0, 0, 0);
      expect_at(0, 639, "a_last_visible", 639, 0, 1, 1, 1, 0, 0, 0);
      expect_at(0, 640, "a_blank_fall",   640, 0, 0, 1, 1, 0, 0, 0);
      expect_at(0, 655, "a_before_hsync", 655, 0, 0, 1, 1, 0, 0, 0);
      expect_at(0, 656, "a_hsync_start",  656, 0, 0, 0, 1, 0, 0, 0);
      expect_at(0, 751, "a_hsync_end",    751, 0, 0, 0, 1, 0, 0, 0);
      expect_at(0, 752, "a_after_hsync",  752, 0, 0, 1, 1, 0, 0, 0);
      expect_at(0, 799, "a_line_end",     799, 0, 0, 1, 1, 0, 0, 0);
      expect_at(0, 800, "a_line_wrap",    0,   1, 1, 1, 1, 0, 0, 0);
      expect_at(0, 1200, "a_before_reset", 400, 1, 1, 1, 1, 0, 0, 0);
      step(800);
      check("a_hs_low_cycles", hs_low_a, 96);
      check("a_hs_low_outside_window", hs_out_a, 0);
      step(400);

      // DUT a: reset mid-line for three cycles.
      rst_a_n = 1'b0;
      base = g;
      expect_at(0, 1, "a_in_reset_1", 0, 0, 1, 1, 1, 0, 0, 0);
      expect_at(0, 2, "a_in_reset_2", 0, 0, 1, 1, 1, 0, 0, 0);
      expect_at(0, 3, "a_in_reset_3", 0, 0, 1, 1, 1, 0, 0, 0);
      step(3);
      rst_a_n = 1'b1;
      base = g;
      fs_cnt_a = 0;
      expect_at(0, 1,   "a_resume_1",   1,   0, 1, 1, 1, 0, 0, 0);
      expect_at(0, 2,   "a_resume_2",   2,   0, 1, 1, 1, 0, 0, 0);
      expect_at(0, 640, "a_resume_640", 640, 0, 0, 1, 1, 0, 0, 0);
      step(700);
      check("a_no_spurious_frame_start", fs_cnt_a, 0);

      // DUT b: one full 7x5 frame.
      rst_b_n = 1'b1;
      base = g;
      blank_b = 0; hs_low_b = 0; vs_low_b = 0; fs_cnt_b = 0; vbs_cnt_b = 0;
      expect_at(1, 1,  "b_first_edge",   1, 0, 1, 1, 1, 0, 0, 0);
      expect_at(1, 3,  "b_last_visible", 3, 0, 1, 1, 1, 0, 0, 0);
      expect_at(1, 4,  "b_blank_fall",   4, 0, 0, 1, 1, 0, 0, 0);
      expect_at(1, 5,  "b_hsync",        5, 0, 0, 0, 1, 0, 0, 0);
      expect_at(1, 6,  "b_hback",        6, 0, 0, 1, 1, 0, 0, 0);
      expect_at(1, 7,  "b_line_wrap",    0, 1, 1, 1, 1, 0, 0, 0);
      expect_at(1, 13, "b_line1_end",    6, 1, 0, 1, 1, 0, 0, 0);
      expect_at(1, 14, "b_vblank_start", 0, 2, 0, 1, 1, 0, 1, 0);
      expect_at(1, 15, "b_vblank_once",  1, 2, 0, 1, 1, 0, 0, 0);
      expect_at(1, 20, "b_before_vsync", 6, 2, 0, 1, 1, 0, 0, 0);
      expect_at(1, 21, "b_vsync_start",  0, 3, 0, 1, 0, 0, 0, 0);
      expect_at(1, 27, "b_vsync_end",    6, 3, 0, 1, 0, 0, 0, 0);
      expect_at(1, 28, "b_after_vsync",  0, 4, 0, 1, 1, 0, 0, 0);
      expect_at(1, 34, "b_frame_end",    6, 4, 0, 1, 1, 0, 0, 0);
      expect_at(1, 35, "b_frame_wrap",   0, 0, 1, 1, 1, 1, 0, 1);
      expect_at(1, 36, "b_frame_pulse_once", 1, 0, 1, 1, 1, 0, 0, 1);
      step(35);
      check("b_blank_cycles_per_frame", blank_b, 8);
      check("b_hs_low_cycles_per_frame", hs_low_b, 5);
      check("b_vs_low_cycles_per_frame", vs_low_b, 7);
      check("b_frame_start_per_frame", fs_cnt_b, 1);
      check("b_vblank_start_per_frame", vbs_cnt_b, 1);
      step(35);
      check("b_frame_period", fs_per_b, 35);

      // DUT b: run to 256 frames for the frame_count wrap.
      expect_at(1, 8925, "b_frame_255",      0, 0, 1, 1, 1, 1, 0, 255);
      expect_at(1, 8926, "b_frame_255_hold", 1, 0, 1, 1, 1, 0, 0, 255);
      expect_at(1, 8959, "b_frame_255_end",  6, 4, 0, 1, 1, 0, 0, 255);
      expect_at(1, 8960, "b_fcount_wrap",    0, 0, 1, 1, 1, 1, 0, 0);
      expect_at(1, 8961, "b_fcount_wrap_hold", 1, 0, 1, 1, 1, 0, 0, 0);
      expect_at(1, 8983, "b_before_reset",   2, 3, 0, 1, 0, 0, 0, 0);
      step(8890);
      check("b_blank_cycles_256_frames", blank_b, 2048);
      check("b_frame_start_256_frames", fs_cnt_b, 256);
      check("b_vblank_start_256_frames", vbs_cnt_b, 256);
      step(23);

      // DUT b: reset mid-frame inside vsync for three cycles.
      rst_b_n = 1'b0;
      base = g;
      expect_at(1, 1, "b_in_reset_1", 0, 0, 1, 1, 1, 0, 0, 0);
      expect_at(1, 2, "b_in_reset_2", 0, 0, 1, 1, 1, 0, 0, 0);
      expect_at(1, 3, "b_in_reset_3", 0, 0, 1, 1, 1, 0, 0, 0);
      step(3);
      rst_b_n = 1'b1;
      base = g;
      fs_cnt_b = 0;
      expect_at(1, 1,  "b_resume_1",         1, 0, 1, 1, 1, 0, 0, 0);
      expect_at(1, 34, "b_resume_frame_end", 6, 4, 0, 1, 1, 0, 0, 0);
      expect_at(1, 35, "b_resume_wrap",      0, 0, 1, 1, 1, 1, 0, 1);
      step(34);
      check("b_no_spurious_frame_start", fs_cnt_b, 0);
      step(3);

      // ---------------- final report ----------------
      check("a_per_cycle_model_errors", err_a, 0);
      check("b_per_cycle_model_errors", err_b, 0);
      check("pending_expectations", tag_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
